fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues addresses to a synchronous ROM, presents
// the returned instruction to decode, and handles stall, jumps and halt.
//
// state | meaning
// IDLE  | waiting for start; nothing valid
// PRIME | first fetch of a new stream in flight; output is a bubble
// RUN   | instr/pc carry a live instruction
// HALT  | halt opcode retired; done held until next start
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  start_addr,
    input  logic        stall,
    input  logic        pc_jmp_abs,
    input  logic        pc_jmp_rel,
    input  logic        branch_taken,
    input  logic [9:0]  jmp_target,
    input  logic [7:0]  jmp_offset,
    output logic [9:0]  imem_addr,
    input  logic [8:0]  imem_rdata,
    output logic [8:0]  instr,
    output logic        instr_valid,
    output logic [9:0]  pc,
    output logic        done,
    output logic [15:0] retired
);

    localparam logic [8:0] HALT_OP = 9'h1FF;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [9:0]  fetch_pc_q, fetch_pc_d;
    logic [9:0]  pc_q, pc_d;
    logic        done_q, done_d;
    logic [15:0] retired_q, retired_d;

    logic        accept;
    logic        is_halt;
    logic        jump_taken;
    logic [9:0]  rel_target;
    logic [9:0]  jump_dest;

    assign accept     = (state_q == RUN) && !stall;
    assign is_halt    = (imem_rdata == HALT_OP);
    assign jump_taken = branch_taken && (pc_jmp_abs || pc_jmp_rel);
    assign rel_target = pc_q + {{2{jmp_offset[7]}}, jmp_offset};
    assign jump_dest  = pc_jmp_abs ? jmp_target : rel_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= 10'd0;
            pc_q       <= 10'd0;
            done_q     <= 1'b0;
            retired_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            done_q     <= done_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        done_d     = done_q;
        retired_d  = retired_q;
        imem_addr  = fetch_pc_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    fetch_pc_d = start_addr;
                    done_d     = 1'b0;
                    retired_d  = 16'd0;
                    state_d    = PRIME;
                end
            end
            PRIME: begin
                pc_d       = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 10'd1;
                state_d    = RUN;
            end
            RUN: begin
                if (!accept) begin
                    // re-read the held instruction so rdata stays put
                    imem_addr = pc_q;
                end else begin
                    if (retired_q != 16'hFFFF)
                        retired_d = retired_q + 16'd1;
                    if (is_halt) begin
                        done_d  = 1'b1;
                        state_d = HALT;
                    end else if (jump_taken) begin
                        fetch_pc_d = jump_dest;
                        state_d    = PRIME;
                    end else begin
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr       = imem_rdata;
    assign instr_valid = (state_q == RUN);
    assign pc          = pc_q;
    assign done        = done_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous ROM, instruction-level reference model,
// per-cycle compare plus directed literal checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic        stall = 1'b0;
    logic        pc_jmp_abs = 1'b0;
    logic        pc_jmp_rel = 1'b0;
    logic        branch_taken = 1'b0;
    logic [9:0]  jmp_target = '0;
    logic [7:0]  jmp_offset = '0;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_rdata;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [9:0]  pc;
    logic        done;
    logic [15:0] retired;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stall(stall), .pc_jmp_abs(pc_jmp_abs), .pc_jmp_rel(pc_jmp_rel),
        .branch_taken(branch_taken), .jmp_target(jmp_target),
        .jmp_offset(jmp_offset), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .done(done), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i & 255);
        rom[5] = 9'h1FF;
    end
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: which instruction is visible, how many cycles
    // until the next one appears, and the retire count.
    logic        m_active = 1'b0;
    int          m_gap = 0;
    logic [9:0]  m_pc = '0;
    int          m_ret = 0;
    logic        m_done = 1'b0;
    int          m_t;
    logic        m_valid;
    assign m_valid = m_active && (m_gap == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_gap = 0; m_pc = '0; m_ret = 0; m_done = 1'b0;
        end else if (m_active && m_gap == 0) begin
            if (!stall) begin
                if (m_ret < 65535) m_ret = m_ret + 1;
                if (rom[m_pc] == 9'h1FF) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else if (branch_taken && (pc_jmp_abs || pc_jmp_rel)) begin
                    if (pc_jmp_abs) m_pc = jmp_target;
                    else begin
                        m_t  = (int'(m_pc) + int'($signed(jmp_offset)) + 1024) % 1024;
                        m_pc = m_t[9:0];
                    end
                    m_gap = 1;
                end else begin
                    m_pc = 10'((int'(m_pc) + 1) % 1024);
                end
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else if (!m_active && start) begin
            m_active = 1'b1; m_gap = 1; m_pc = start_addr; m_ret = 0; m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("instr_valid", int'(instr_valid), int'(m_valid));
            chk("done", int'(done), int'(m_done));
            chk("retired", int'(retired), m_ret);
            if (m_valid) begin
                chk("pc", int'(pc), int'(m_pc));
                chk("instr", int'(instr), int'(rom[m_pc]));
            end
        end
    end

    task automatic drive(input logic st, input logic [9:0] sa, input logic sl,
                         input logic ja, input logic jr, input logic tk,
                         input logic [9:0] tg, input logic [7:0] off);
        start = st; start_addr = sa; stall = sl; pc_jmp_abs = ja;
        pc_jmp_rel = jr; branch_taken = tk; jmp_target = tg; jmp_offset = off;
        @(posedge clk);
        @(negedge clk);
        #1;
        start = 1'b0; stall = 1'b0; pc_jmp_abs = 1'b0; pc_jmp_rel = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic idle_cyc();
        drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
    endtask

    task automatic run_to(input logic [9:0] target);
        int n;
        n = 0;
        while (!(m_valid && m_pc == target) && n < 2000) begin
            idle_cyc();
            n++;
        end
        chk("run_to_reached", int'(m_valid && m_pc == target), 1);
    endtask

    initial begin
        #12;
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_pc", int'(pc), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        idle_cyc();
        chk("idle_valid", int'(instr_valid), 0);

        // start at 0x010: bubble, then consecutive pcs
        drive(1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        chk("prime_valid", int'(instr_valid), 0);
        idle_cyc();
        chk("first_valid", int'(instr_valid), 1);
        chk("first_pc", int'(pc), 'h010);
        idle_cyc();
        chk("second_pc", int'(pc), 'h011);
        idle_cyc();
        chk("third_pc", int'(pc), 'h012);
        chk("third_ret", int'(retired), 2);

        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
            chk("stall_pc", int'(pc), 'h012);
            chk("stall_instr", int'(instr), 'h012);
            chk("stall_ret", int'(retired), 2);
        end
        idle_cyc();
        chk("post_stall_pc", int'(pc), 'h013);
        chk("post_stall_ret", int'(retired), 3);

        // relative jump back by 16
        run_to(10'h020);
        drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 8'hF0);
        chk("rel_bubble", int'(instr_valid), 0);
        idle_cyc();
        chk("rel_pc", int'(pc), 'h010);

        // absolute jump to 0x3FF, then wrap to 0
        drive(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h3FF, 8'd0);
        chk("abs_bubble", int'(instr_valid), 0);
        idle_cyc();
        chk("abs_pc", int'(pc), 'h3FF);
        idle_cyc();
        chk("wrap_pc", int'(pc), 'h000);

        // untaken jump: no bubble
        drive(1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h200, 8'h40);
        chk("untaken_valid", int'(instr_valid), 1);
        chk("untaken_pc", int'(pc), 'h001);

        // both requests taken: absolute wins
        drive(1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h004, 8'h10);
        chk("both_bubble", int'(instr_valid), 0);
        idle_cyc();
        chk("both_pc", int'(pc), 'h004);
        idle_cyc();
        chk("halt_op_pc", int'(pc), 'h005);
        idle_cyc();
        chk("halt_done", int'(done), 1);
        chk("halt_valid", int'(instr_valid), 0);
        idle_cyc();
        idle_cyc();

        // restart from HALT at 0; start pulse during RUN is ignored
        drive(1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        chk("restart_done", int'(done), 0);
        chk("restart_ret", int'(retired), 0);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        chk("ign_pre_pc", int'(pc), 'h002);
        drive(1'b1, 10'h200, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        chk("ign_start_pc", int'(pc), 'h003);
        idle_cyc();
        idle_cyc();
        chk("halt2_pc", int'(pc), 'h005);
        chk("halt2_pre_ret", int'(retired), 5);
        idle_cyc();
        chk("halt2_done", int'(done), 1);
        chk("halt2_valid", int'(instr_valid), 0);
        chk("halt2_ret", int'(retired), 6);
        drive(1'b1, 10'h100, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        chk("halt2_restart_done", int'(done), 0);
        chk("halt2_restart_ret", int'(retired), 0);
        for (int k = 0; k < 4; k++) idle_cyc();
        chk("prereset_valid", int'(instr_valid), 1);

        // asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(instr_valid), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_ret", int'(retired), 0);
        chk("arst_pc", int'(pc), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle_cyc();
            chk("post_rst_idle", int'(instr_valid), 0);
        end

        // mixed traffic with random stalls and jumps
        drive(1'b1, 10'h300, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        for (int k = 0; k < 80; k++) begin
            drive(1'b0, 10'd0, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), 10'($urandom_range(256, 1023)),
                  8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
